// File: rtl/wb_frame_pkg.sv
// ---------------------------------------------------------------------------
// wb_frame_pkg
// Shared types and constants for the frame read-back path.
//   frame_state_t  : reader FSM states
//   BYTES_PER_WORD : pixels packed into one 32-bit memory word
//   ADR_STEP       : byte-address increment between consecutive words
//   TS_OFFSET      : offset of the timestamp word from the frame start
//                    (same layout the camera write path produces)
//   cntWidth()     : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package wb_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_TS,
        RD_PX,
        EMIT,
        DONE
    } frame_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADR_STEP       = 4;
    localparam int TS_OFFSET      = 0;

    // A dimension of 1 would give $clog2() == 0, which is not a legal width.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_frame_reader_if.sv
// ---------------------------------------------------------------------------
// wb_frame_reader_if
// Wishbone classic read-only bus between the frame reader (master) and the
// frame RAM arbiter (slave).
//   m_wb_cyc / m_wb_stb : cycle and strobe, master -> slave
//   m_wb_adr            : word-aligned byte address, master -> slave
//   m_wb_we             : write enable, always 0 from this master
//   m_i_wb_dat          : read data, slave -> master
//   m_wb_ack            : acknowledge, slave -> master
// ---------------------------------------------------------------------------
interface wb_frame_reader_if #(
    parameter int ADR_WIDTH = 15
) ();

    logic                 m_wb_cyc;
    logic                 m_wb_stb;
    logic [ADR_WIDTH-1:0] m_wb_adr;
    logic                 m_wb_we;
    logic [31:0]          m_i_wb_dat;
    logic                 m_wb_ack;

    modport master (
        output m_wb_cyc,
        output m_wb_stb,
        output m_wb_adr,
        output m_wb_we,
        input  m_i_wb_dat,
        input  m_wb_ack
    );

    modport slave (
        input  m_wb_cyc,
        input  m_wb_stb,
        input  m_wb_adr,
        input  m_wb_we,
        output m_i_wb_dat,
        output m_wb_ack
    );

endinterface

// File: rtl/wb_word_unpacker.sv
// ---------------------------------------------------------------------------
// wb_word_unpacker
// Holds one 32-bit memory word and hands it out as four bytes, LSB first,
// over a valid/ready handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_load        : load i_word and start emitting from byte 0
//   i_word        : word to unpack
//   i_ready       : downstream accept
//   o_dat, o_vld  : current byte and its valid
//   o_word_done   : strobe in the cycle the last byte of the word transfers
// ---------------------------------------------------------------------------
module wb_word_unpacker
    import wb_frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_ready,
    output logic [7:0]  o_dat,
    output logic        o_vld,
    output logic        o_word_done
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    logic [31:0]      r_word;
    logic [IDX_W-1:0] r_idx;
    logic             r_vld;
    logic             w_xfer;
    logic             w_lastByte;

    assign w_xfer     = r_vld & i_ready;
    assign w_lastByte = (r_idx == IDX_W'(BYTES_PER_WORD - 1));

    // Word register and byte index; valid drops right after the last byte
    // so the owner can start the next bus read in the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
            r_vld  <= 1'b0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
            r_vld  <= 1'b1;
        end else if (w_xfer) begin
            r_idx <= r_idx + IDX_W'(1);
            if (w_lastByte) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign o_dat       = r_word[{r_idx, 3'b000} +: 8];
    assign o_vld       = r_vld;
    // Combinational so the FSM can leave EMIT on the same edge the last byte
    // transfers, keeping the word-to-word gap at one bus cycle.
    assign o_word_done = w_xfer & w_lastByte;

endmodule

// File: rtl/wb_frame_reader.sv
// ---------------------------------------------------------------------------
// wb_frame_reader
// Wishbone master that reads one stored frame (timestamp word followed by
// ROWS x COLS pixels packed four per word, first pixel in bits [7:0]) and
// replays it as a byte stream with frame/line markers.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle pulse to begin a frame (ignored if busy)
//   rd_addr_start       : byte address of the timestamp word
//   busy, done          : frame in progress / one-cycle completion pulse
//   timestamp           : timestamp word of the current/last frame
//   o_dat, o_vld        : pixel byte and valid
//   o_ready             : downstream accept
//   o_sof, o_eol, o_eof : first of frame / last of line / last of frame
//   wb                  : Wishbone classic master port (read only)
// ---------------------------------------------------------------------------
module wb_frame_reader
    import wb_frame_pkg::*;
#(
    parameter int ADR_WIDTH = 15,
    parameter int ROWS      = 120,
    parameter int COLS      = 160
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADR_WIDTH-1:0] rd_addr_start,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          timestamp,
    output logic [7:0]           o_dat,
    output logic                 o_vld,
    input  logic                 o_ready,
    output logic                 o_sof,
    output logic                 o_eol,
    output logic                 o_eof,
    wb_frame_reader_if.master    wb
);

    localparam int COL_W = cntWidth(COLS);
    localparam int ROW_W = cntWidth(ROWS);

    frame_state_t         r_state;
    logic [ADR_WIDTH-1:0] r_adr;
    logic                 r_cyc;
    logic                 r_busy;
    logic                 r_done;
    logic [31:0]          r_ts;
    logic [ROW_W-1:0]     r_row;
    logic [COL_W-1:0]     r_col;

    logic                 w_ack;
    logic                 w_load;
    logic                 w_vld;
    logic                 w_xfer;
    logic                 w_wordDone;
    logic                 w_lastCol;
    logic                 w_lastRow;
    logic                 w_lastPix;

    // A late ack while the bus is idle must never reach the FSM or unpacker.
    assign w_ack     = r_cyc & wb.m_wb_ack;
    assign w_load    = (r_state == RD_PX) & w_ack;
    assign w_xfer    = w_vld & o_ready;
    assign w_lastCol = (r_col == COL_W'(COLS - 1));
    assign w_lastRow = (r_row == ROW_W'(ROWS - 1));
    assign w_lastPix = w_lastCol & w_lastRow;

    wb_word_unpacker u_unpacker (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_word      (wb.m_i_wb_dat),
        .i_ready     (o_ready),
        .o_dat       (o_dat),
        .o_vld       (w_vld),
        .o_word_done (w_wordDone)
    );

    // Frame sequencer: one outstanding bus read at a time, never overlapped
    // with pixel emission. Bus and status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_adr   <= '0;
            r_cyc   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ts    <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_adr   <= rd_addr_start + ADR_WIDTH'(TS_OFFSET);
                        r_row   <= '0;
                        r_col   <= '0;
                        r_cyc   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RD_TS;
                    end
                end
                RD_TS: begin
                    // Keep cyc/stb up so the first pixel word follows at once.
                    if (w_ack) begin
                        r_ts    <= wb.m_i_wb_dat;
                        r_adr   <= r_adr + ADR_WIDTH'(ADR_STEP);
                        r_state <= RD_PX;
                    end
                end
                RD_PX: begin
                    if (w_ack) begin
                        r_cyc   <= 1'b0;
                        r_adr   <= r_adr + ADR_WIDTH'(ADR_STEP);
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_xfer) begin
                        if (w_lastCol) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                    end
                    // COLS is a multiple of 4, so the frame always ends on
                    // the last byte of a word.
                    if (w_wordDone) begin
                        if (w_lastPix) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cyc   <= 1'b1;
                            r_state <= RD_PX;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign wb.m_wb_cyc = r_cyc;
    assign wb.m_wb_stb = r_cyc;
    assign wb.m_wb_adr = r_adr;
    assign wb.m_wb_we  = 1'b0;

    assign busy      = r_busy;
    assign done      = r_done;
    assign timestamp = r_ts;
    assign o_vld     = w_vld;

    // Markers qualify the byte on o_dat and are forced low without valid.
    assign o_sof = w_vld & (r_row == '0) & (r_col == '0);
    assign o_eol = w_vld & w_lastCol;
    assign o_eof = w_vld & w_lastPix;

endmodule

// File: tb/tb_wb_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_wb_frame_reader
// Directed bench for wb_frame_reader with ROWS=2, COLS=8: a memory-backed
// Wishbone slave with programmable wait states, and a negedge monitor that
// logs bus addresses and pixel transfers for the checks.
// ---------------------------------------------------------------------------
module tb_wb_frame_reader;

    localparam int ADR_WIDTH = 15;
    localparam int ROWS      = 2;
    localparam int COLS      = 8;
    localparam int NPIX      = ROWS * COLS;
    localparam int NWORDS    = NPIX / 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [ADR_WIDTH-1:0] rdAddrStart = '0;
    logic                 busy;
    logic                 done;
    logic [31:0]          timestamp;
    logic [7:0]           oDat;
    logic                 oVld;
    logic                 oReady = 1'b1;
    logic                 oSof;
    logic                 oEol;
    logic                 oEof;

    int compared   = 0;
    int mismatched = 0;

    wb_frame_reader_if #(.ADR_WIDTH(ADR_WIDTH)) wbBus ();

    wb_frame_reader #(
        .ADR_WIDTH (ADR_WIDTH),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .rd_addr_start (rdAddrStart),
        .busy          (busy),
        .done          (done),
        .timestamp     (timestamp),
        .o_dat         (oDat),
        .o_vld         (oVld),
        .o_ready       (oReady),
        .o_sof         (oSof),
        .o_eol         (oEol),
        .o_eof         (oEof),
        .wb            (wbBus)
    );

    always #5 clk = ~clk;

    // Cycle numbering: cycleCnt is the index of the cycle that follows the
    // most recent rising edge.
    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Memory-backed slave: ack comes after waitStates stalled cycles.
    logic [31:0] mem [0:8191];
    int waitStates = 0;
    int waitCnt = 0;

    always @* begin
        wbBus.m_wb_ack   = wbBus.m_wb_cyc && wbBus.m_wb_stb && (waitCnt == waitStates);
        wbBus.m_i_wb_dat = mem[wbBus.m_wb_adr[14:2]];
    end

    always @(posedge clk) begin
        if (!rst_n)
            waitCnt <= 0;
        else if (wbBus.m_wb_cyc && wbBus.m_wb_stb && !wbBus.m_wb_ack)
            waitCnt <= waitCnt + 1;
        else
            waitCnt <= 0;
    end

    // Monitor: logs acked addresses and transfers, counts protocol slips.
    logic [ADR_WIDTH-1:0] adrQ [$];
    logic [10:0]          pixQ [$];
    int                   cycQ [$];
    int                   holdViol = 0;
    int                   stallViol = 0;
    int                   markViol = 0;
    logic                 prevWait = 1'b0;
    logic                 prevStall = 1'b0;
    logic [ADR_WIDTH-1:0] prevAdr = '0;
    logic [7:0]           prevDat = '0;
    logic [2:0]           prevMk = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prevWait  <= 1'b0;
            prevStall <= 1'b0;
        end else begin
            if (wbBus.m_wb_cyc && wbBus.m_wb_stb && wbBus.m_wb_ack)
                adrQ.push_back(wbBus.m_wb_adr);
            if (prevWait && (!(wbBus.m_wb_cyc && wbBus.m_wb_stb) || wbBus.m_wb_adr !== prevAdr))
                holdViol <= holdViol + 1;
            if (prevStall && (!oVld || oDat !== prevDat || {oSof, oEol, oEof} !== prevMk))
                stallViol <= stallViol + 1;
            if (!oVld && (oSof || oEol || oEof))
                markViol <= markViol + 1;
            if (oVld && oReady) begin
                pixQ.push_back({oSof, oEol, oEof, oDat});
                cycQ.push_back(cycleCnt);
            end
            prevWait  <= wbBus.m_wb_cyc && wbBus.m_wb_stb && !wbBus.m_wb_ack;
            prevAdr   <= wbBus.m_wb_adr;
            prevStall <= oVld && !oReady;
            prevDat   <= oDat;
            prevMk    <= {oSof, oEol, oEof};
        end
    end

    // Per-frame snapshots taken by applyStimulus.
    int pixBase, adrBase, holdBase, stallBase, markBase;
    int startCycle, doneCycle;
    bit doneSeen;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fillFrame(input logic [ADR_WIDTH-1:0] addr, input logic [31:0] ts, input logic [7:0] base);
        logic [ADR_WIDTH-1:0] a;
        logic [7:0] b;
        mem[addr[14:2]] = ts;
        for (int w = 0; w < NWORDS; w++) begin
            a = addr + ADR_WIDTH'(4 + 4 * w);
            b = base + 8'(4 * w);
            mem[a[14:2]] = {b + 8'd3, b + 8'd2, b + 8'd1, b};
        end
    endtask

    // Runs one frame: start pulse, optional ready toggling and extra start
    // pulses (mid-frame and in the DONE cycle), then waits for done.
    task automatic applyStimulus(input int ws, input bit toggle, input logic [ADR_WIDTH-1:0] addr,
                                 input bit midStart, input bit doneStart);
        waitStates = ws;
        pixBase   = pixQ.size();
        adrBase   = adrQ.size();
        holdBase  = holdViol;
        stallBase = stallViol;
        markBase  = markViol;
        doneSeen  = 1'b0;
        doneCycle = 0;
        @(posedge clk); #1;
        oReady      = 1'b1;
        rdAddrStart = addr;
        start       = 1'b1;
        startCycle  = cycleCnt;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("req_issue", {wbBus.m_wb_cyc, wbBus.m_wb_stb, busy}, 3'b111);
        checkOutput("req_adr", wbBus.m_wb_adr, addr);
        for (int n = 0; n < 4000; n++) begin
            if (toggle) oReady = ~oReady;
            if (midStart && (pixQ.size() - pixBase) == 5) begin
                rdAddrStart = 15'h0300;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                doneSeen  = 1'b1;
                doneCycle = cycleCnt;
                if (doneStart) begin
                    rdAddrStart = 15'h0300;
                    start = 1'b1;
                end
                break;
            end
            @(posedge clk); #1;
        end
        checkOutput("done_seen", doneSeen, 1'b1);
        checkOutput("busy_in_done", busy, 1'b1);
        @(posedge clk); #1;
        start  = 1'b0;
        oReady = 1'b1;
        checkOutput("idle_after_done", {busy, done}, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_new_req", {wbBus.m_wb_cyc, busy}, 2'b00);
    endtask

    task automatic checkFrame(input string name, input logic [ADR_WIDTH-1:0] addr, input logic [31:0] ts,
                              input logic [7:0] base, input int ws, input bit timed);
        logic [10:0] expPix;
        logic [10:0] obsPix;
        logic [ADR_WIDTH-1:0] expAdr;
        int last;
        checkOutput({name, "_ts"}, timestamp, ts);
        checkOutput({name, "_npix"}, pixQ.size() - pixBase, NPIX);
        checkOutput({name, "_nadr"}, adrQ.size() - adrBase, NWORDS + 1);
        for (int k = 0; k <= NWORDS; k++) begin
            expAdr = addr + ADR_WIDTH'(4 * k);
            checkOutput({name, "_adr"}, (adrBase + k < adrQ.size()) ? adrQ[adrBase + k] : 15'h7FFF, expAdr);
        end
        for (int i = 0; i < NPIX; i++) begin
            expPix = {i == 0, (i % COLS) == COLS - 1, i == NPIX - 1, base + 8'(i)};
            obsPix = (pixBase + i < pixQ.size()) ? pixQ[pixBase + i] : 11'h7FF;
            checkOutput({name, "_pix"}, obsPix, expPix);
        end
        last = pixBase + NPIX - 1;
        checkOutput({name, "_done_lat"}, (last < cycQ.size()) ? doneCycle - cycQ[last] : -1, 1);
        if (timed) begin
            checkOutput({name, "_first_lat"}, (pixBase < cycQ.size()) ? cycQ[pixBase] - startCycle : -1, 3 + 2 * ws);
            for (int i = 1; i < NPIX; i++) begin
                checkOutput({name, "_gap"}, (pixBase + i < cycQ.size()) ? cycQ[pixBase + i] - cycQ[pixBase + i - 1] : -1,
                            ((i % 4) == 0) ? 2 + ws : 1);
            end
        end
        checkOutput({name, "_hold"}, holdViol - holdBase, 0);
        checkOutput({name, "_stall"}, stallViol - stallBase, 0);
        checkOutput({name, "_mark"}, markViol - markBase, 0);
    endtask

    initial begin
        $display("[TB] wb_frame_reader bench start");
        fillFrame(15'h0100, 32'hDEADBEEF, 8'h00);
        fillFrame(15'h0200, 32'hCAFEF00D, 8'h20);
        fillFrame(15'h7FFC, 32'h12345678, 8'h40);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ctrl", {wbBus.m_wb_cyc, wbBus.m_wb_stb, wbBus.m_wb_we, busy, done, oVld, oSof, oEol, oEof}, 9'd0);
        checkOutput("rst_adr", wbBus.m_wb_adr, 15'h0000);
        checkOutput("rst_ts", timestamp, 32'h0);
        checkOutput("rst_dat", oDat, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-wait slave, ready always high
        applyStimulus(0, 1'b0, 15'h0100, 1'b0, 1'b0);
        checkFrame("zw", 15'h0100, 32'hDEADBEEF, 8'h00, 0, 1'b1);

        // Three wait states per access
        applyStimulus(3, 1'b0, 15'h0100, 1'b0, 1'b0);
        checkFrame("ws3", 15'h0100, 32'hDEADBEEF, 8'h00, 3, 1'b1);

        // Ready toggling every cycle
        applyStimulus(0, 1'b1, 15'h0100, 1'b0, 1'b0);
        checkFrame("tog", 15'h0100, 32'hDEADBEEF, 8'h00, 0, 1'b0);

        // Start pulses mid-frame and in the DONE cycle are dropped
        applyStimulus(0, 1'b0, 15'h0100, 1'b1, 1'b1);
        checkFrame("restart", 15'h0100, 32'hDEADBEEF, 8'h00, 0, 1'b1);

        // Asynchronous reset while a pixel read is outstanding
        waitStates = 3;
        @(posedge clk); #1;
        rdAddrStart = 15'h0100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (wbBus.m_wb_stb === 1'b1 && wbBus.m_wb_adr === 15'h0104) break;
            @(posedge clk); #1;
        end
        checkOutput("pre_rst_rdpx", {wbBus.m_wb_stb, wbBus.m_wb_adr}, {1'b1, 15'h0104});
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ctrl", {wbBus.m_wb_cyc, wbBus.m_wb_stb, oVld, busy}, 4'b0000);
        checkOutput("async_rst_adr_ts", {wbBus.m_wb_adr, timestamp}, {15'h0000, 32'h0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1'b0, 15'h0200, 1'b0, 1'b0);
        checkFrame("after_rst", 15'h0200, 32'hCAFEF00D, 8'h20, 0, 1'b1);

        // Address wrap across the top of the 15-bit space
        applyStimulus(0, 1'b0, 15'h7FFC, 1'b0, 1'b0);
        checkFrame("wrap", 15'h7FFC, 32'h12345678, 8'h40, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
